// File: rtl/pmem_arbiter_if.sv
// pmem_arbiter_if: bundles the I-cache, D-cache and physical-memory sides
// of the pmem arbiter. "slave" is the arbiter's view; "master" is the
// environment's view (both caches plus physical memory).
interface pmem_arbiter_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 128
);
  logic                  i_pmem_read;
  logic [ADDR_WIDTH-1:0] i_pmem_address;
  logic [LINE_WIDTH-1:0] i_pmem_rdata;
  logic                  i_pmem_resp;

  logic                  d_pmem_read;
  logic                  d_pmem_write;
  logic [ADDR_WIDTH-1:0] d_pmem_address;
  logic [LINE_WIDTH-1:0] d_pmem_wdata;
  logic [LINE_WIDTH-1:0] d_pmem_rdata;
  logic                  d_pmem_resp;

  logic                  pmem_read;
  logic                  pmem_write;
  logic [ADDR_WIDTH-1:0] pmem_address;
  logic [LINE_WIDTH-1:0] pmem_wdata;
  logic [LINE_WIDTH-1:0] pmem_rdata;
  logic                  pmem_resp;

  modport slave (
    input  i_pmem_read, i_pmem_address,
    output i_pmem_rdata, i_pmem_resp,
    input  d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
    output d_pmem_rdata, d_pmem_resp,
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_rdata, pmem_resp
  );

  modport master (
    output i_pmem_read, i_pmem_address,
    input  i_pmem_rdata, i_pmem_resp,
    output d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
    input  d_pmem_rdata, d_pmem_resp,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_rdata, pmem_resp
  );
endinterface

// File: rtl/pmem_arbiter.sv
// pmem_arbiter: shares one physical-memory port between the I-cache fill
// path and the D-cache fill/writeback path. One requester is granted at a
// time; its command is latched so requester-side changes mid-grant are
// invisible to memory. Only the resp strobe is steered; rdata fans out.
//
// Optional feature macro: PMEM_ARB_ROUND_ROBIN_EN
//   defined   -> alternate grants on conflict (D wins the first after reset)
//   undefined -> D always wins conflicts (I can starve)
//
// state   | meaning
// IDLE    | no grant; pick a winner and latch its request
// GRANT_I | latched I-cache read driven to memory, waiting for pmem_resp
// GRANT_D | latched D-cache read/write driven to memory, waiting for pmem_resp
module pmem_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 128
) (
  input logic           clk,
  input logic           reset,
  pmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LINE_WIDTH-1:0] wdata_q;
  logic                  write_q;

  logic i_req, d_req, take, pick_d;

  assign i_req = bus.i_pmem_read;
  assign d_req = bus.d_pmem_read | bus.d_pmem_write;
  assign take  = (state == IDLE) && (i_req || d_req);

`ifdef PMEM_ARB_ROUND_ROBIN_EN
  logic last_grant;  // 0 = I granted last, 1 = D granted last

  // Remember who won the most recent grant for conflict alternation.
  always_ff @(posedge clk) begin
    if (reset)     last_grant <= 1'b0;
    else if (take) last_grant <= pick_d;
  end

  assign pick_d = d_req && (!i_req || !last_grant);
`else
  assign pick_d = d_req;
`endif

  // Latch the winner's command on the grant edge; an illegal read+write
  // from the D side resolves to a write.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
    end else if (take) begin
      if (pick_d) begin
        addr_q  <= bus.d_pmem_address;
        wdata_q <= bus.d_pmem_wdata;
        write_q <= bus.d_pmem_write;
      end else begin
        addr_q  <= bus.i_pmem_address;
        write_q <= 1'b0;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next state, memory command and steered resp; resp is suppressed while
  // reset is high so a coincident pmem_resp never reaches a cache.
  always_comb begin
    state_next      = state;
    bus.pmem_read   = 1'b0;
    bus.pmem_write  = 1'b0;
    bus.i_pmem_resp = 1'b0;
    bus.d_pmem_resp = 1'b0;
    case (state)
      IDLE: begin
        if (i_req || d_req) state_next = pick_d ? GRANT_D : GRANT_I;
      end
      GRANT_I: begin
        bus.pmem_read = 1'b1;
        if (bus.pmem_resp) begin
          bus.i_pmem_resp = !reset;
          state_next      = IDLE;
        end
      end
      GRANT_D: begin
        bus.pmem_read  = !write_q;
        bus.pmem_write = write_q;
        if (bus.pmem_resp) begin
          bus.d_pmem_resp = !reset;
          state_next      = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.pmem_address = addr_q;
  assign bus.pmem_wdata   = wdata_q;
  assign bus.i_pmem_rdata = bus.pmem_rdata;
  assign bus.d_pmem_rdata = bus.pmem_rdata;

`ifndef SYNTHESIS
  illegal_d_cmd: assert property (@(posedge clk) disable iff (reset)
    !(bus.d_pmem_read && bus.d_pmem_write));
`endif

endmodule
